// File: rtl/control_fsm_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit: opcodes, FSM states,
// trap causes and datapath mux encodings.
package control_fsm_pkg;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {
      ST_RESET,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
      ST_TRAP,
      ST_HALTED
   } state_t;

   localparam logic [1:0] CAUSE_NONE    = 2'd0;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

   localparam logic       ADDR_ALU  = 1'b0;
   localparam logic       ADDR_PC   = 1'b1;

   localparam logic [1:0] RD_ALU    = 2'd0;
   localparam logic [1:0] RD_MEM    = 2'd1;
   localparam logic [1:0] RD_CSR    = 2'd2;

   localparam logic [1:0] ALU1_RS1  = 2'd0;
   localparam logic [1:0] ALU1_PC   = 2'd1;
   localparam logic [1:0] ALU1_ZERO = 2'd2;

   localparam logic [1:0] ALU2_RS2  = 2'd0;
   localparam logic [1:0] ALU2_IMM  = 2'd1;
   localparam logic [1:0] ALU2_SIZE = 2'd2;

   typedef struct packed {
      logic       write_rd;
      logic       write_csr;
      logic [1:0] rd_sel;
      logic [1:0] alu1;
      logic [1:0] alu2;
   } exec_ctl_t;

endpackage

// File: rtl/control_fsm_if.sv
// Control bundle between the sequencer (master) and the datapath/memory/debug side (slave).
interface control_fsm_if;

   logic [6:0] opcode;
   logic [2:0] f3;
   logic       mem_complete;
   logic       halt_req;
   logic       resume_req;

   logic       load_op;
   logic       write_pc;
   logic       write_ir;
   logic       write_rd;
   logic       write_csr;
   logic       mem_read;
   logic       mem_write;
   logic       addr_sel;
   logic [1:0] rd_sel;
   logic [1:0] alu_insel1;
   logic [1:0] alu_insel2;
   logic       halted;
   logic       trap;
   logic [1:0] trap_cause;
   logic       retire;

   modport master (
      input  opcode, f3, mem_complete, halt_req, resume_req,
      output load_op, write_pc, write_ir, write_rd, write_csr, mem_read, mem_write,
             addr_sel, rd_sel, alu_insel1, alu_insel2, halted, trap, trap_cause, retire
   );

   modport slave (
      output opcode, f3, mem_complete, halt_req, resume_req,
      input  load_op, write_pc, write_ir, write_rd, write_csr, mem_read, mem_write,
             addr_sel, rd_sel, alu_insel1, alu_insel2, halted, trap, trap_cause, retire
   );

endinterface

// File: rtl/control_fsm_decode.sv
// Combinational opcode decode: legality, memory-class flags and the EXEC-cycle select set.
module control_fsm_decode
   import control_fsm_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] f3,
   output logic       legal,
   output logic       is_mem,
   output logic       is_load,
   output exec_ctl_t  ctl
);

   always_comb begin
      legal   = 1'b1;
      is_mem  = 1'b0;
      is_load = 1'b0;
      ctl     = '0;
      case (opcode)
         OP_LUI: begin
            ctl.write_rd = 1'b1;
            ctl.alu1     = ALU1_ZERO;
            ctl.alu2     = ALU2_IMM;
         end
         OP_AUIPC: begin
            ctl.write_rd = 1'b1;
            ctl.alu1     = ALU1_PC;
            ctl.alu2     = ALU2_IMM;
         end
         OP_JAL, OP_JALR: begin
            ctl.write_rd = 1'b1;
            ctl.alu1     = ALU1_PC;
            ctl.alu2     = ALU2_SIZE;
         end
         OP_BRANCH: begin
            ctl.alu1 = ALU1_RS1;
            ctl.alu2 = ALU2_RS2;
         end
         OP_LOAD: begin
            is_mem  = 1'b1;
            is_load = 1'b1;
         end
         OP_STORE: begin
            is_mem = 1'b1;
         end
         OP_IMM: begin
            ctl.write_rd = 1'b1;
            ctl.alu1     = ALU1_RS1;
            ctl.alu2     = ALU2_IMM;
         end
         OP_OP: begin
            ctl.write_rd = 1'b1;
            ctl.alu1     = ALU1_RS1;
            ctl.alu2     = ALU2_RS2;
         end
         OP_FENCE: begin
            legal = 1'b1;
         end
         OP_SYSTEM: begin
            // f3 == 0 is ECALL/EBREAK, which this core does not implement
            legal         = (f3 != 3'b000);
            ctl.write_rd  = 1'b1;
            ctl.write_csr = 1'b1;
            ctl.rd_sel    = RD_CSR;
         end
         default: begin
            legal = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle RV32I sequencer: drives datapath strobes/selects, debug halt/resume,
// illegal-instruction and memory-timeout traps.
//
// state   | meaning
// RESET   | leaving reset, all outputs idle
// FETCH   | instruction read at PC, IR written on mem_complete
// DECODE  | idle cycle while the IR settles into the decoder
// EXEC    | single-cycle ALU/branch/jump/CSR instruction, retires
// MEM     | load/store access at ALU address, retires on mem_complete
// TRAP    | sticky trap, only debug halt leaves it
// HALTED  | debug halt, resume goes to FETCH (or back to TRAP)
module control_fsm
   import control_fsm_pkg::*;
#(
   parameter int MEM_TIMEOUT = 0,
   parameter int TIMEOUT_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   control_fsm_if.master    bus
);

   localparam bit                   TO_EN   = (MEM_TIMEOUT != 0);
   localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(MEM_TIMEOUT - 1);

   state_t                state_q, state_d;
   logic [TIMEOUT_W-1:0]  cnt_q, cnt_d;
   logic                  trap_q, trap_d;
   logic [1:0]            cause_q, cause_d;

   logic       legal, is_mem, is_load;
   exec_ctl_t  ctl;
   logic       req_wait, timeout_hit;

   logic       load_op, write_pc, write_ir, write_rd, write_csr;
   logic       mem_read, mem_write, addr_sel, retire;
   logic [1:0] rd_sel, alu1, alu2;

   control_fsm_decode u_decode (
      .opcode  (bus.opcode),
      .f3      (bus.f3),
      .legal   (legal),
      .is_mem  (is_mem),
      .is_load (is_load),
      .ctl     (ctl)
   );

   assign req_wait    = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !bus.mem_complete;
   assign timeout_hit = TO_EN && req_wait && (cnt_q == TO_LAST);

   // Counter is zero whenever no access is waiting, so entry to FETCH/MEM always starts from 0
   assign cnt_d = (TO_EN && req_wait && !timeout_hit) ? cnt_q + 1'b1 : '0;

   always_comb begin
      state_d   = state_q;
      trap_d    = trap_q;
      cause_d   = cause_q;
      load_op   = 1'b0;
      write_pc  = 1'b0;
      write_ir  = 1'b0;
      write_rd  = 1'b0;
      write_csr = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      addr_sel  = ADDR_ALU;
      rd_sel    = RD_ALU;
      alu1      = ALU1_RS1;
      alu2      = ALU2_RS2;
      retire    = 1'b0;
      case (state_q)
         ST_RESET: begin
            state_d = bus.halt_req ? ST_HALTED : ST_FETCH;
         end
         ST_FETCH: begin
            mem_read = 1'b1;
            addr_sel = ADDR_PC;
            if (bus.mem_complete) begin
               write_ir = 1'b1;
               state_d  = ST_DECODE;
            end else if (timeout_hit) begin
               state_d = ST_TRAP;
               trap_d  = 1'b1;
               cause_d = CAUSE_TIMEOUT;
            end
         end
         ST_DECODE: begin
            if (!legal) begin
               state_d = ST_TRAP;
               trap_d  = 1'b1;
               cause_d = CAUSE_ILLEGAL;
            end else begin
               state_d = is_mem ? ST_MEM : ST_EXEC;
            end
         end
         ST_EXEC: begin
            write_pc  = 1'b1;
            retire    = 1'b1;
            write_rd  = ctl.write_rd;
            write_csr = ctl.write_csr;
            rd_sel    = ctl.rd_sel;
            alu1      = ctl.alu1;
            alu2      = ctl.alu2;
            state_d   = bus.halt_req ? ST_HALTED : ST_FETCH;
         end
         ST_MEM: begin
            addr_sel  = ADDR_ALU;
            alu1      = ALU1_RS1;
            alu2      = ALU2_IMM;
            mem_read  = is_load;
            load_op   = is_load;
            mem_write = !is_load;
            if (bus.mem_complete) begin
               write_pc = 1'b1;
               retire   = 1'b1;
               write_rd = is_load;
               rd_sel   = is_load ? RD_MEM : RD_ALU;
               state_d  = bus.halt_req ? ST_HALTED : ST_FETCH;
            end else if (timeout_hit) begin
               state_d = ST_TRAP;
               trap_d  = 1'b1;
               cause_d = CAUSE_TIMEOUT;
            end
         end
         ST_TRAP: begin
            if (bus.halt_req) begin
               state_d = ST_HALTED;
            end
         end
         ST_HALTED: begin
            // trap_q is sticky, so it also records that HALTED was entered from TRAP
            if (bus.resume_req && !bus.halt_req) begin
               state_d = trap_q ? ST_TRAP : ST_FETCH;
            end
         end
         default: begin
            state_d = ST_RESET;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RESET;
         cnt_q   <= '0;
         trap_q  <= 1'b0;
         cause_q <= CAUSE_NONE;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         trap_q  <= trap_d;
         cause_q <= cause_d;
      end
   end

   assign bus.load_op    = load_op;
   assign bus.write_pc   = write_pc;
   assign bus.write_ir   = write_ir;
   assign bus.write_rd   = write_rd;
   assign bus.write_csr  = write_csr;
   assign bus.mem_read   = mem_read;
   assign bus.mem_write  = mem_write;
   assign bus.addr_sel   = addr_sel;
   assign bus.rd_sel     = rd_sel;
   assign bus.alu_insel1 = alu1;
   assign bus.alu_insel2 = alu2;
   assign bus.retire     = retire;
   assign bus.halted     = (state_q == ST_HALTED);
   assign bus.trap       = trap_q;
   assign bus.trap_cause = cause_q;

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: directed scenarios then random instruction streams, each cycle
// compared against expectations built from an instruction-class table.
module tb_control_fsm;

   localparam int TMO = 4;

   typedef struct packed {
      logic       load_op;
      logic       write_pc;
      logic       write_ir;
      logic       write_rd;
      logic       write_csr;
      logic       mem_read;
      logic       mem_write;
      logic       addr_sel;
      logic [1:0] rd_sel;
      logic [1:0] alu1;
      logic [1:0] alu2;
      logic       halted;
      logic       trap;
      logic [1:0] cause;
      logic       retire;
   } obs_t;

   // kind: 0 = single-cycle execute, 1 = load, 2 = store
   typedef struct {
      logic [6:0] op;
      int         kind;
      bit         need_f3;
      bit         wr_rd;
      bit         wr_csr;
      logic [1:0] rd_sel;
      logic [1:0] a1;
      logic [1:0] a2;
   } ref_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;
   ref_t tbl [11];

   control_fsm_if bus ();

   control_fsm #(.MEM_TIMEOUT(TMO), .TIMEOUT_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   task automatic init_tbl();
      //          op          kind f3 rd csr rdsel a1    a2
      tbl[0]  = '{7'b0110111, 0,   0, 1, 0,  2'd0, 2'd2, 2'd1};
      tbl[1]  = '{7'b0010111, 0,   0, 1, 0,  2'd0, 2'd1, 2'd1};
      tbl[2]  = '{7'b1101111, 0,   0, 1, 0,  2'd0, 2'd1, 2'd2};
      tbl[3]  = '{7'b1100111, 0,   0, 1, 0,  2'd0, 2'd1, 2'd2};
      tbl[4]  = '{7'b1100011, 0,   0, 0, 0,  2'd0, 2'd0, 2'd0};
      tbl[5]  = '{7'b0000011, 1,   0, 0, 0,  2'd0, 2'd0, 2'd0};
      tbl[6]  = '{7'b0100011, 2,   0, 0, 0,  2'd0, 2'd0, 2'd0};
      tbl[7]  = '{7'b0010011, 0,   0, 1, 0,  2'd0, 2'd0, 2'd1};
      tbl[8]  = '{7'b0110011, 0,   0, 1, 0,  2'd0, 2'd0, 2'd0};
      tbl[9]  = '{7'b0001111, 0,   0, 0, 0,  2'd0, 2'd0, 2'd0};
      tbl[10] = '{7'b1110011, 0,   1, 1, 1,  2'd2, 2'd0, 2'd0};
   endtask

   function automatic int find_row(input logic [6:0] op, input logic [2:0] f);
      for (int i = 0; i < 11; i++) begin
         if (tbl[i].op == op && !(tbl[i].need_f3 && f == 3'b000)) return i;
      end
      return -1;
   endfunction

   function automatic obs_t sample();
      obs_t o;
      o.load_op   = bus.load_op;
      o.write_pc  = bus.write_pc;
      o.write_ir  = bus.write_ir;
      o.write_rd  = bus.write_rd;
      o.write_csr = bus.write_csr;
      o.mem_read  = bus.mem_read;
      o.mem_write = bus.mem_write;
      o.addr_sel  = bus.addr_sel;
      o.rd_sel    = bus.rd_sel;
      o.alu1      = bus.alu_insel1;
      o.alu2      = bus.alu_insel2;
      o.halted    = bus.halted;
      o.trap      = bus.trap;
      o.cause     = bus.trap_cause;
      o.retire    = bus.retire;
      return o;
   endfunction

   task automatic check_now(input obs_t exp, input string tag);
      obs_t got;
      got = sample();
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Inputs are set at the falling edge; outputs are checked 1 time unit later
   task automatic step(input obs_t exp, input string tag);
      #1;
      check_now(exp, tag);
      @(negedge clk);
   endtask

   task automatic do_reset(input bit hreq);
      obs_t e;
      bus.mem_complete = 1'b0;
      bus.resume_req   = 1'b0;
      bus.halt_req     = hreq;
      rst_n = 1'b0;
      #1;
      e = '0;
      check_now(e, "in_reset");
      @(negedge clk);
      rst_n = 1'b1;
      step(e, "reset_state");
      if (hreq) begin
         e.halted = 1'b1;
         step(e, "halt_from_reset");
         bus.halt_req   = 1'b0;
         bus.resume_req = 1'b1;
         step(e, "resume_from_reset");
         bus.resume_req = 1'b0;
      end
   endtask

   task automatic trap_tail(input logic [1:0] cause, input bit hreq);
      obs_t e;
      e = '0;
      e.trap  = 1'b1;
      e.cause = cause;
      step(e, "trap_entry");
      if (hreq) begin
         bus.halt_req   = 1'b0;
         bus.resume_req = 1'b1;
         e.halted = 1'b1;
         step(e, "trap_halted");
         bus.resume_req = 1'b0;
         e.halted = 1'b0;
         step(e, "trap_resumed");
      end else begin
         bus.mem_complete = 1'b1;
         step(e, "trap_hold");
         bus.mem_complete = 1'b0;
      end
   endtask

   // fl/ml: cycle of mem_complete for fetch/data access, 0 = never (timeout)
   task automatic run_instr(input logic [6:0] op, input logic [2:0] f, input int fl,
                            input int ml, input bit hreq, output bit trapped);
      obs_t e;
      int   r;
      bit   mc;
      trapped = 1'b0;
      bus.opcode   = op;
      bus.f3       = f;
      bus.halt_req = hreq;
      for (int k = 1; k <= TMO; k++) begin
         mc = (k == fl);
         bus.mem_complete = mc;
         e = '0;
         e.mem_read = 1'b1;
         e.addr_sel = 1'b1;
         e.write_ir = mc;
         step(e, "fetch");
         if (mc) break;
      end
      if (fl == 0) begin
         bus.mem_complete = 1'b0;
         trap_tail(2'd2, hreq);
         trapped = 1'b1;
         return;
      end
      bus.mem_complete = 1'($urandom);
      e = '0;
      step(e, "decode");
      r = find_row(op, f);
      if (r < 0) begin
         bus.mem_complete = 1'b0;
         trap_tail(2'd1, hreq);
         trapped = 1'b1;
         return;
      end
      if (tbl[r].kind == 0) begin
         e = '0;
         e.write_pc  = 1'b1;
         e.retire    = 1'b1;
         e.write_rd  = tbl[r].wr_rd;
         e.write_csr = tbl[r].wr_csr;
         e.rd_sel    = tbl[r].rd_sel;
         e.alu1      = tbl[r].a1;
         e.alu2      = tbl[r].a2;
         step(e, "exec");
      end else begin
         for (int k = 1; k <= TMO; k++) begin
            mc = (k == ml);
            bus.mem_complete = mc;
            e = '0;
            e.addr_sel  = 1'b0;
            e.alu1      = 2'd0;
            e.alu2      = 2'd1;
            e.mem_read  = (tbl[r].kind == 1);
            e.load_op   = (tbl[r].kind == 1);
            e.mem_write = (tbl[r].kind == 2);
            if (mc) begin
               e.write_pc = 1'b1;
               e.retire   = 1'b1;
               e.write_rd = (tbl[r].kind == 1);
               e.rd_sel   = (tbl[r].kind == 1) ? 2'd1 : 2'd0;
            end
            step(e, (tbl[r].kind == 1) ? "load" : "store");
            if (mc) break;
         end
         bus.mem_complete = 1'b0;
         if (ml == 0) begin
            trap_tail(2'd2, hreq);
            trapped = 1'b1;
            return;
         end
      end
      bus.mem_complete = 1'b0;
      if (hreq) begin
         e = '0;
         e.halted = 1'b1;
         if ($urandom_range(0, 1) == 1) begin
            bus.resume_req = 1'b1;
            step(e, "halt_resume_blocked");
         end
         bus.halt_req   = 1'b0;
         bus.resume_req = 1'b1;
         step(e, "halted");
         bus.resume_req = 1'b0;
      end
      bus.halt_req = 1'b0;
   endtask

   task automatic reset_mid_access();
      obs_t e;
      bus.opcode       = 7'b0110011;
      bus.f3           = 3'b000;
      bus.halt_req     = 1'b0;
      bus.mem_complete = 1'b0;
      e = '0;
      e.mem_read = 1'b1;
      e.addr_sel = 1'b1;
      step(e, "fetch_before_reset");
      step(e, "fetch_before_reset");
      #2;
      rst_n = 1'b0;
      #1;
      e = '0;
      check_now(e, "reset_drops_request");
      @(negedge clk);
      rst_n = 1'b1;
      step(e, "reset_state");
   endtask

   initial begin
      bit trapped;
      bus.opcode       = '0;
      bus.f3           = '0;
      bus.mem_complete = 1'b0;
      bus.halt_req     = 1'b0;
      bus.resume_req   = 1'b0;
      init_tbl();
      @(negedge clk);

      do_reset(1'b0);
      run_instr(7'b0010011, 3'b000, 3, 0, 1'b0, trapped);   // ADDI
      run_instr(7'b0000011, 3'b010, 1, 2, 1'b0, trapped);   // LW
      run_instr(7'b0100011, 3'b010, 2, 4, 1'b0, trapped);   // SW, completes at the limit
      run_instr(7'b1110011, 3'b001, 1, 0, 1'b0, trapped);   // CSRRW
      run_instr(7'b0000011, 3'b010, 1, 3, 1'b1, trapped);   // halt during load
      run_instr(7'b0110111, 3'b000, 4, 0, 1'b0, trapped);   // LUI, fetch completes at the limit
      run_instr(7'b1111111, 3'b000, 1, 0, 1'b0, trapped);   // illegal
      do_reset(1'b0);
      run_instr(7'b1110011, 3'b000, 1, 0, 1'b1, trapped);   // ECALL, then halt/resume in trap
      do_reset(1'b0);
      run_instr(7'b0010011, 3'b000, 0, 0, 1'b0, trapped);   // fetch timeout
      do_reset(1'b1);
      run_instr(7'b0000011, 3'b000, 2, 0, 1'b0, trapped);   // load timeout
      do_reset(1'b0);
      reset_mid_access();
      run_instr(7'b1101111, 3'b000, 2, 0, 1'b1, trapped);   // JAL with halt

      for (int it = 0; it < 120; it++) begin
         logic [6:0] op;
         logic [2:0] f;
         int         fl;
         int         ml;
         bit         h;
         if ($urandom_range(0, 3) == 0) op = 7'($urandom);
         else                           op = tbl[$urandom_range(0, 10)].op;
         f  = 3'($urandom);
         fl = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, TMO));
         ml = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TMO));
         h  = ($urandom_range(0, 3) == 0);
         run_instr(op, f, fl, ml, h, trapped);
         if (trapped) do_reset($urandom_range(0, 3) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/control_fsm.md
Name: control_fsm

Overview:
- Multi-cycle RV32I control unit: the sequencing end of the core's control-signal bundle.
- Consumes opcode/f3 from the datapath's instruction register and mem_complete from the memory port.
- Drives all datapath strobes and mux selects (PC/IR/RD/CSR writes, memory read/write, address, RD source, ALU operand selects).
- Adds debug halt/resume and a memory-timeout trap.

Parameters:
- MEM_TIMEOUT, 0, max cycles to wait for mem_complete per access; 0 disables the timeout.
- TIMEOUT_W, 8, width of the timeout counter; MEM_TIMEOUT must be < 2**TIMEOUT_W.

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- opcode  input  7  IR[6:0].
- f3  input  3  IR[14:12].
- mem_complete  input  1  current memory access finishes this cycle.
- halt_req  input  1  debug halt request, level.
- resume_req  input  1  debug resume, pulse.
- load_op  output  1  memory read is a data load (datapath applies f3 extension).
- write_pc, write_ir, write_rd, write_csr  output  1 each  register write strobes.
- mem_read, mem_write  output  1 each  memory request, held until mem_complete.
- addr_sel  output  1  0=ALU, 1=PC.
- rd_sel  output  2  0=ALU, 1=MEM, 2=CSR.
- alu_insel1  output  2  0=RS1, 1=PC, 2=zero.
- alu_insel2  output  2  0=RS2, 1=IMM, 2=instruction size (4).
- halted  output  1  core is in HALTED.
- trap  output  1  sticky; illegal instruction or bus timeout seen.
- trap_cause  output  2  0=none, 1=illegal, 2=timeout.
- retire  output  1  one-cycle pulse per completed instruction.

Behaviour:
- Asynchronous reset: state=RESET, timeout counter=0, trap=0, trap_cause=0.
- All outputs are combinational functions of state/opcode/f3/mem_complete. Outputs not listed for a state are 0.
- RESET: all outputs 0. Next state is HALTED if halt_req, else FETCH.
- FETCH: mem_read=1, addr_sel=PC. On mem_complete: write_ir=1, next state DECODE.
- DECODE: one idle cycle, all strobes 0.
  - Legal opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011, FENCE 0001111, SYSTEM 1110011 with f3!=0.
  - LOAD/STORE go to MEM; any illegal opcode goes to TRAP (cause=1); everything else goes to EXEC.
- EXEC: single cycle; asserts write_pc=1 and retire=1, then goes to FETCH. Per opcode:
  - LUI: write_rd, alu1=zero, alu2=IMM.
  - AUIPC: write_rd, alu1=PC, alu2=IMM.
  - JAL/JALR: write_rd, alu1=PC, alu2=size. Next-PC target is resolved in the datapath.
  - BRANCH: alu1=RS1, alu2=RS2. The datapath resolves taken/not-taken.
  - OP-IMM: write_rd, alu1=RS1, alu2=IMM.
  - OP: write_rd, alu1=RS1, alu2=RS2.
  - FENCE: no other strobes.
  - SYSTEM (CSR): write_rd with rd_sel=CSR, and write_csr=1.
- MEM: addr_sel=ALU, alu1=RS1, alu2=IMM.
  - LOAD: mem_read=1, load_op=1. On mem_complete: write_rd=1, rd_sel=MEM, write_pc=1, retire=1, next state FETCH.
  - STORE: mem_write=1. On mem_complete: write_pc=1, retire=1, next state FETCH.
- Timeout (MEM_TIMEOUT>0):
  - Counter clears on entry to FETCH/MEM and increments each cycle without mem_complete.
  - When the count reaches MEM_TIMEOUT, go to TRAP with cause=2 and drop the request the same cycle.
  - mem_complete in the same cycle as the limit wins: no trap.
- TRAP: all strobes 0. trap=1 and trap_cause hold until reset. Waits there permanently; halt_req moves it to HALTED, and halted is valid there.
- HALTED: halted=1, strobes 0. resume_req goes to FETCH; if the core entered HALTED from TRAP, resume returns to TRAP.
- Halt timing:
  - halt_req is sampled only at instruction boundaries: on the retire cycle (next state becomes HALTED instead of FETCH) and in RESET.
  - halt_req never aborts an in-flight memory access.
  - resume_req and halt_req both high in HALTED: stay halted.
- Reset mid-access: the request drops immediately (asynchronous); no write strobes are issued.

Decomposition:
- Shared package: opcode constants, state enum (RESET, FETCH, DECODE, EXEC, MEM, TRAP, HALTED), trap-cause codes, and mux encodings ADDR/RD/ALU1/ALU2.
- Package defines the mux encodings with the same values as the existing core control macros.
- One sub-module: control_decode. Purely combinational, maps opcode/f3 to legal, is_mem, and the per-opcode select/strobe set used by EXEC/MEM.
- Counter and state register stay in control_fsm.

Test Plan:
- Reset release, ADDI (opcode 0010011), mem_complete on 3rd FETCH cycle:
  - mem_read/addr_sel=1 for 3 cycles; write_ir at cycle 3.
  - DECODE idle, then EXEC with write_rd=1, alu1=0, alu2=1, write_pc=1, retire=1.
- LW (f3=010), load mem_complete after 2 cycles: MEM shows load_op=1 and addr_sel=0 for 2 cycles; the final cycle has write_rd=1, rd_sel=1, write_pc=1.
- Opcode 1111111: DECODE goes to TRAP; trap=1, trap_cause=1; no write_pc thereafter.
- MEM_TIMEOUT=4, mem_complete never arrives in FETCH: after 4 cycles mem_read=0, trap_cause=2. A repeat run with mem_complete on exactly cycle 4 must not trap.
- halt_req raised mid-load: load completes and retires, halted=1 next cycle; resume_req pulse returns to FETCH with mem_read=1 the following cycle.
- CSRRW (1110011, f3=001): EXEC shows rd_sel=2, write_rd=1, write_csr=1. ECALL (f3=000) traps with cause=1.
